// File: rtl/anc_uart_pkg.sv
// Shared state encoding, LED codes and bit-timing/parity helpers for the UART sample loader.
// Optional macro UART_RX_PARITY_EN selects even-parity framing (8E1) instead of 8N1.
package anc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5,
        ST_WRITE     = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_RX    = 4'b0010;
    localparam logic [3:0] LED_WRITE = 4'b0100;
    localparam logic [3:0] LED_DONE  = 4'b1000;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive engine: rx synchronizer plus start/data/stop bit sequencing.
// With UART_RX_PARITY_EN defined, an even-parity bit is checked between D7 and the stop bit.
module uart_rx_core
    import anc_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rx_serial,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       busy
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    logic [1:0]       sync_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             par_ok_r;
    logic             rx_s;
    logic             bit_end_s;
    logic             mid_s;

    assign rx_s      = sync_r[1];
    assign bit_end_s = (cnt_r == CNT_W'(CPB - 1));
    assign mid_s     = (cnt_r == CNT_W'(HALF - 1));
    assign busy      = (state_r != ST_IDLE);

    // Two-flop synchronizer, preset to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_serial};
        end
    end

    // Bit engine: frames one byte and emits a single-cycle valid or error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_ok_r   <= 1'b1;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (enable && !rx_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (!rx_s) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                            par_ok_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        shift_r <= {rx_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        par_ok_r <= (rx_s == even_parity(shift_r));
                        state_r  <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (rx_s) begin
                            state_r <= ST_IDLE;
                            if (par_ok_r) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shift_r;
                            end else begin
                                byte_err <= 1'b1;
                            end
                        end else begin
                            // Line still low at stop: wait for it to release before hunting a new start.
                            byte_err <= 1'b1;
                            state_r  <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_to_bram.sv
// Loads DEPTH UART-received samples sequentially into BRAM port A, then raises load_done.
// Optional macro UART_RX_PARITY_EN (handled in uart_rx_core) enables even-parity framing.
module uart_to_bram
    import anc_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              rx_serial,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              load_done,
    output logic              frame_err,
    output logic [3:0]        debug_led
);

    state_t          state_r;
    logic [ADDR_W:0] ptr_r;
    logic            rx_enable_s;
    logic            byte_valid_s;
    logic [7:0]      byte_data_s;
    logic            byte_err_s;
    logic            rx_busy_s;

    // New frames are only accepted while loading is enabled and the buffer is not full.
    assign rx_enable_s = load && (state_r != ST_DONE);

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (rx_enable_s),
        .rx_serial  (rx_serial),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .byte_err   (byte_err_s),
        .busy       (rx_busy_s)
    );

    // Write sequencing: one BRAM write per received byte until DEPTH samples are stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {(ADDR_W+1){1'b0}};
            ena       <= 1'b0;
            wea       <= 1'b0;
            addr      <= {ADDR_W{1'b0}};
            din       <= {DATA_W{1'b0}};
            load_done <= 1'b0;
            frame_err <= 1'b0;
            debug_led <= LED_IDLE;
        end else begin
            ena <= 1'b0;
            wea <= 1'b0;
            if (byte_err_s) begin
                frame_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (byte_valid_s) begin
                        state_r   <= ST_WRITE;
                        ena       <= 1'b1;
                        wea       <= 1'b1;
                        addr      <= ptr_r[ADDR_W-1:0];
                        din       <= byte_data_s;
                        ptr_r     <= ptr_r + (ADDR_W+1)'(1);
                        debug_led <= LED_WRITE;
                    end else begin
                        debug_led <= rx_busy_s ? LED_RX : LED_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (ptr_r == (ADDR_W+1)'(DEPTH)) begin
                        state_r   <= ST_DONE;
                        load_done <= 1'b1;
                        debug_led <= LED_DONE;
                    end else begin
                        state_r   <= ST_IDLE;
                        debug_led <= rx_busy_s ? LED_RX : LED_IDLE;
                    end
                end
                ST_DONE: begin
                    load_done <= 1'b1;
                    debug_led <= LED_DONE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    debug_led <= LED_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_to_bram.sv
// Directed bench for uart_to_bram: scoreboard of expected BRAM writes checked by a write monitor.
// Honors UART_RX_PARITY_EN to frame bytes with even parity and run the parity-error case.
module tb_uart_to_bram;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 10;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 8;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b1;
    logic              load      = 1'b0;
    logic              rx_serial = 1'b1;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              load_done;
    logic              frame_err;
    logic [3:0]        debug_led;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t sb[$];
    int  total     = 0;
    int  bad       = 0;
    int  wr_count  = 0;
    int  exp_wr    = 0;
    int  cyc       = 0;
    int  last_wr   = 0;
    int  done_cyc  = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    uart_to_bram #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .rx_serial (rx_serial),
        .ena       (ena),
        .wea       (wea),
        .addr      (addr),
        .din       (din),
        .load_done (load_done),
        .frame_err (frame_err),
        .debug_led (debug_led)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every ena pulse must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (load_done === 1'b1 && done_prev === 1'b0) done_cyc = cyc;
            done_prev = load_done;
            if (ena === 1'b1) begin
                wr_count++;
                last_wr = cyc;
                check("write_expected", 64'(sb.size() > 0), 64'd1);
                check("wea_eq_ena", 64'(wea), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(addr), 64'(e.addr));
                    check("wr_din", 64'(din), 64'(e.data));
                end
            end
        end
    end

    task automatic bit_out(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(^d);
`endif
        bit_out(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] d, input logic par);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(par);
        bit_out(1'b1);
    endtask
`endif

    task automatic send_good(input logic [7:0] d, input logic [ADDR_W-1:0] a);
        sb.push_back(wr_t'{addr: a, data: d});
        exp_wr++;
        send_byte(d, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rx_serial = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] part;
        part = 8'hA5;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ena", 64'(ena), 64'd0);
        check("rst_wea", 64'(wea), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_din", 64'(din), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_debug_led", 64'(debug_led), 64'b0001);
        reset_n = 1'b1;
        load    = 1'b1;
        repeat (3) @(negedge clk);

        // Fill the buffer with back-to-back frames.
        send_good(8'h05, 0);
        send_good(8'hFB, 1);
        send_good(8'h7F, 2);
        send_good(8'h80, 3);
        drain("drain_fill");
        repeat (3) @(negedge clk);
        check("fill_load_done", 64'(load_done), 64'd1);
        check("fill_debug_led", 64'(debug_led), 64'b1000);
        check("done_latency", 64'(done_cyc), 64'(last_wr + 1));
        check("fill_frame_err", 64'(frame_err), 64'd0);
        check("fill_wr_count", 64'(wr_count), 64'(exp_wr));

        // Extra byte after done is ignored.
        send_byte(8'h11, 1'b1);
        repeat (20) @(negedge clk);
        check("post_done_wr_count", 64'(wr_count), 64'(exp_wr));
        check("post_done_addr", 64'(addr), 64'd3);
        check("post_done_load_done", 64'(load_done), 64'd1);

        // Short low glitch in IDLE.
        do_reset();
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_frame_err", 64'(frame_err), 64'd0);
        check("glitch_wr_count", 64'(wr_count), 64'(exp_wr));
        check("glitch_debug_led", 64'(debug_led), 64'b0001);

        // Bad stop bit: sticky error, byte dropped, next good byte at addr 0.
        send_byte(8'h3C, 1'b0);
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        check("stop_err_frame_err", 64'(frame_err), 64'd1);
        check("stop_err_wr_count", 64'(wr_count), 64'(exp_wr));
        send_good(8'h3C, 0);
        drain("drain_after_stop_err");
        check("frame_err_sticky", 64'(frame_err), 64'd1);

        // Reset during bit 4 of the second byte.
        send_good(8'h01, 1);
        drain("drain_before_midreset");
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(part[i]);
        rx_serial = part[4];
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_ena", 64'(ena), 64'd0);
        check("midrst_addr", 64'(addr), 64'd0);
        check("midrst_din", 64'(din), 64'd0);
        check("midrst_frame_err", 64'(frame_err), 64'd0);
        check("midrst_debug_led", 64'(debug_led), 64'b0001);
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_write", 64'(wr_count), 64'(exp_wr));
        send_good(8'h10, 0);
        send_good(8'hF0, 1);
        send_good(8'h55, 2);
        send_good(8'hAA, 3);
        drain("drain_refill");
        repeat (3) @(negedge clk);
        check("refill_load_done", 64'(load_done), 64'd1);

        // load low blocks new frames.
        do_reset();
        load = 1'b0;
        send_byte(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("load_off_wr_count", 64'(wr_count), 64'(exp_wr));
        check("load_off_debug_led", 64'(debug_led), 64'b0001);
        load = 1'b1;
        repeat (5) @(negedge clk);
        send_good(8'h22, 0);
        drain("drain_load_on");

        // load dropped mid-frame: the frame still completes.
        fork
            send_good(8'h33, 1);
            begin
                repeat (30) @(negedge clk);
                load = 1'b0;
            end
        join
        drain("drain_load_drop");
        load = 1'b1;
        check("wr_count_final", 64'(wr_count), 64'(exp_wr));

`ifdef UART_RX_PARITY_EN
        do_reset();
        send_byte_par(8'h03, 1'b1);
        repeat (20) @(negedge clk);
        check("par_err_frame_err", 64'(frame_err), 64'd1);
        check("par_err_wr_count", 64'(wr_count), 64'(exp_wr));
        sb.push_back(wr_t'{addr: 0, data: 8'h03});
        exp_wr++;
        send_byte_par(8'h03, 1'b0);
        drain("drain_par_ok");
        check("par_ok_wr_count", 64'(wr_count), 64'(exp_wr));
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
